// File: rtl/mem_dump_unit.sv
// mem_dump_unit: on the halt instruction, freezes the CPU and streams data memory words 0..DEPTH-1 with their index.
// Latency: out_valid rises two edges after the halt edge, then one word per cycle while out_ready stays high.
// Backpressure: out_valid/out_index/out_data hold until accepted. Optional MEM_DUMP_CHECKSUM_EN adds a running sum.
module mem_dump_unit #(
    parameter int          DEPTH     = 64,
    parameter int          IDX_W     = 6,
    parameter logic [31:0] HALT_WORD = 32'h0000_0000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      instr,
    output logic             cpu_hold,
    output logic [31:0]      mem_a,
    input  logic [31:0]      mem_rd,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [IDX_W-1:0] out_index,
    output logic [31:0]      out_data,
    output logic             done,
    output logic [31:0]      checksum
);

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_FILL   = 2'd1;
    localparam logic [1:0] ST_STREAM = 2'd2;
    localparam logic [1:0] ST_DONE   = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);

    logic [1:0]       state_q, state_d;
    logic [IDX_W:0]   rd_ptr_q, rd_ptr_d;
    logic             out_valid_q, out_valid_d;
    logic [IDX_W-1:0] out_index_q, out_index_d;
    logic [31:0]      out_data_q, out_data_d;
    logic             done_q, done_d;
    logic             handshake;

    assign handshake = out_valid_q & out_ready;
    assign cpu_hold  = (state_q != ST_RUN);
    assign out_valid = out_valid_q;
    assign out_index = out_index_q;
    assign out_data  = out_data_q;
    assign done      = done_q;

    // Dump read address: prefetch the word after the one being presented while streaming.
    always_comb begin
        mem_a = 32'h0;
        if (state_q == ST_STREAM) begin
            mem_a = 32'(rd_ptr_q) << 2;
        end
    end

    // Next-state logic for the dump walk and the output register.
    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        out_valid_d = out_valid_q;
        out_index_d = out_index_q;
        out_data_d  = out_data_q;
        done_d      = done_q;
        case (state_q)
            ST_RUN: begin
                if (instr == HALT_WORD) begin
                    state_d = ST_FILL;
                end
            end
            ST_FILL: begin
                out_data_d  = mem_rd;
                out_index_d = '0;
                out_valid_d = 1'b1;
                rd_ptr_d    = (IDX_W+1)'(1);
                state_d     = ST_STREAM;
            end
            ST_STREAM: begin
                if (handshake) begin
                    if (out_index_q == LAST_IDX) begin
                        out_valid_d = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_DONE;
                    end else begin
                        out_data_d  = mem_rd;
                        out_index_d = rd_ptr_q[IDX_W-1:0];
                        rd_ptr_d    = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: begin
                // Terminal until reset; further halt words are ignored.
                out_valid_d = 1'b0;
                done_d      = 1'b1;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= ST_RUN;
            rd_ptr_q    <= '0;
            out_valid_q <= 1'b0;
            out_index_q <= '0;
            out_data_q  <= 32'h0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            out_valid_q <= out_valid_d;
            out_index_q <= out_index_d;
            out_data_q  <= out_data_d;
            done_q      <= done_d;
        end
    end

`ifdef MEM_DUMP_CHECKSUM_EN
    logic [31:0] checksum_q, checksum_d;

    assign checksum = checksum_q;

    // Wrap-around sum of every accepted word; frozen once the dump is done.
    always_comb begin
        checksum_d = checksum_q;
        if (handshake) begin
            checksum_d = checksum_q + out_data_q;
        end
    end

    // Checksum register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            checksum_q <= 32'h0;
        end else begin
            checksum_q <= checksum_d;
        end
    end
`else
    assign checksum = 32'h0;
`endif

endmodule

// File: tb/tb_mem_dump_unit.sv
module tb_mem_dump_unit;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

`ifdef MEM_DUMP_CHECKSUM_EN
    localparam logic [31:0] SUM4 = 32'd110;
    localparam logic [31:0] SUM1 = 32'hDEAD_BEEF;
`else
    localparam logic [31:0] SUM4 = 32'h0;
    localparam logic [31:0] SUM1 = 32'h0;
`endif

    // DEPTH=4 instance
    logic        rst4_n, ready4, hold4, valid4, done4;
    logic [31:0] instr4, mem_a4, mem_rd4, data4, sum4;
    logic [1:0]  idx4;
    logic [31:0] mem4 [4];

    assign mem_rd4 = (mem_a4[31:2] < 30'd4) ? mem4[mem_a4[3:2]] : 32'hBAD0_BAD0;

    mem_dump_unit #(.DEPTH(4), .IDX_W(2), .HALT_WORD(32'h0)) u4 (
        .clk(clk), .rst_n(rst4_n), .instr(instr4), .cpu_hold(hold4),
        .mem_a(mem_a4), .mem_rd(mem_rd4), .out_valid(valid4), .out_ready(ready4),
        .out_index(idx4), .out_data(data4), .done(done4), .checksum(sum4)
    );

    // DEPTH=1 instance
    logic        rst1_n, ready1, hold1, valid1, done1;
    logic [31:0] instr1, mem_a1, mem_rd1, data1, sum1;
    logic [0:0]  idx1;

    assign mem_rd1 = (mem_a1 == 32'h0) ? 32'hDEAD_BEEF : 32'h0BAD_0BAD;

    mem_dump_unit #(.DEPTH(1), .IDX_W(1), .HALT_WORD(32'h0)) u1 (
        .clk(clk), .rst_n(rst1_n), .instr(instr1), .cpu_hold(hold1),
        .mem_a(mem_a1), .mem_rd(mem_rd1), .out_valid(valid1), .out_ready(ready1),
        .out_index(idx1), .out_data(data1), .done(done1), .checksum(sum1)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs are driven and outputs sampled on the falling edge.
    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk_word4(input string tag, input logic [31:0] idx, input logic [31:0] dat);
        chk({tag, ".valid"}, 32'(valid4), 32'd1);
        chk({tag, ".index"}, 32'(idx4), idx);
        chk({tag, ".data"},  data4, dat);
    endtask

    initial begin
        mem4[0] = 32'd11; mem4[1] = 32'd22; mem4[2] = 32'd33; mem4[3] = 32'd44;
        rst4_n = 1'b0; instr4 = 32'h0; ready4 = 1'b1;
        rst1_n = 1'b0; instr1 = 32'h2008_0005; ready1 = 1'b1;
        @(negedge clk);

        // Reset held two cycles with the halt word present
        cyc(); cyc();
        chk("rst.hold",  32'(hold4),  32'd0);
        chk("rst.valid", 32'(valid4), 32'd0);
        chk("rst.done",  32'(done4),  32'd0);
        chk("rst.sum",   sum4,        32'd0);
        chk("rst.index", 32'(idx4),   32'd0);
        chk("rst.data",  data4,       32'd0);
        chk("rst.mem_a", mem_a4,      32'd0);

        // Full-rate dump: release with instr=0, next edge is the halt edge N
        rst4_n = 1'b1;
        cyc();                                        // after N
        chk("fill.hold",  32'(hold4),  32'd1);
        chk("fill.valid", 32'(valid4), 32'd0);
        chk("fill.mem_a", mem_a4,      32'd0);
        instr4 = 32'h2008_0005;
        cyc(); chk_word4("fr0", 0, 11);               // after N+1
        chk("fr0.mem_a", mem_a4, 32'd4);
        cyc(); chk_word4("fr1", 1, 22);
        cyc(); chk_word4("fr2", 2, 33);
        cyc(); chk_word4("fr3", 3, 44);
        chk("fr3.done", 32'(done4), 32'd0);
        cyc();                                        // after N+5
        chk("fr.done",  32'(done4),  32'd1);
        chk("fr.valid", 32'(valid4), 32'd0);
        chk("fr.hold",  32'(hold4),  32'd1);
        chk("fr.sum",   sum4,        SUM4);
        instr4 = 32'h0;
        cyc(); cyc();
        chk("done.stay",  32'(done4), 32'd1);
        chk("done.mem_a", mem_a4,     32'd0);
        chk("done.valid", 32'(valid4), 32'd0);
        chk("done.sum",   sum4,        SUM4);

        // Reset out of DONE, then non-halt traffic for 20 cycles
        rst4_n = 1'b0; instr4 = 32'h2008_0005;
        cyc();
        chk("rst2.hold", 32'(hold4), 32'd0);
        chk("rst2.done", 32'(done4), 32'd0);
        chk("rst2.sum",  sum4,       32'd0);
        rst4_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            cyc();
            chk("run.hold",  32'(hold4),  32'd0);
            chk("run.valid", 32'(valid4), 32'd0);
            chk("run.mem_a", mem_a4,      32'd0);
        end

        // Back-pressure dump
        instr4 = 32'h0;
        cyc();
        chk("bp.hold", 32'(hold4), 32'd1);
        instr4 = 32'h2008_0005;
        cyc(); chk_word4("bp0", 0, 11);
        cyc(); chk_word4("bp1", 1, 22);
        ready4 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(); chk_word4("bp.stall", 1, 22);
        end
        ready4 = 1'b1;
        cyc(); chk_word4("bp2", 2, 33);

        // Reset mid-dump while index 2 is presented
        rst4_n = 1'b0;
        cyc();
        chk("mid.valid", 32'(valid4), 32'd0);
        chk("mid.hold",  32'(hold4),  32'd0);
        chk("mid.done",  32'(done4),  32'd0);
        chk("mid.sum",   sum4,        32'd0);
        chk("mid.index", 32'(idx4),   32'd0);
        rst4_n = 1'b1; instr4 = 32'h0;
        cyc();
        instr4 = 32'h2008_0005;
        cyc(); chk_word4("re0", 0, 11);
        cyc(); chk_word4("re1", 1, 22);
        cyc(); chk_word4("re2", 2, 33);
        cyc(); chk_word4("re3", 3, 44);
        cyc();
        chk("re.done", 32'(done4), 32'd1);
        chk("re.sum",  sum4,       SUM4);

        // DEPTH=1: single word then DONE; later halt words ignored
        rst1_n = 1'b1; instr1 = 32'h0;
        cyc();
        chk("d1.hold",  32'(hold1),  32'd1);
        chk("d1.valid", 32'(valid1), 32'd0);
        ready1 = 1'b0;
        cyc();
        chk("d1.valid1", 32'(valid1), 32'd1);
        chk("d1.index",  32'(idx1),   32'd0);
        chk("d1.data",   data1,       32'hDEAD_BEEF);
        cyc();
        chk("d1.stall.valid", 32'(valid1), 32'd1);
        chk("d1.stall.done",  32'(done1),  32'd0);
        ready1 = 1'b1;
        cyc();
        chk("d1.done",  32'(done1),  32'd1);
        chk("d1.valid0", 32'(valid1), 32'd0);
        chk("d1.sum",   sum1,        SUM1);
        cyc(); cyc();
        chk("d1.again.valid", 32'(valid1), 32'd0);
        chk("d1.again.done",  32'(done1),  32'd1);
        chk("d1.again.hold",  32'(hold1),  32'd1);
        chk("d1.again.mem_a", mem_a1,      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_dump_unit.md
# mem_dump_unit

Halt-triggered data-memory dump engine for the single-cycle MIPS CPU test environment. Watches the instruction word fetched from instruction memory and, when the halt word appears, freezes the CPU and walks data memory from word 0 to DEPTH-1. Each word is emitted on a valid/ready stream with its index. It replaces ad-hoc end-of-run memory printing with a synthesizable, back-pressure-aware dump path that a trace sink or UART bridge consumes.

## Interface
Parameters:
- DEPTH, 64, number of 32-bit data-memory words to dump (>= 1)
- IDX_W, 6, width of word index (2^IDX_W >= DEPTH)
- HALT_WORD, 32'h0000_0000, instruction word that triggers the dump

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- instr  in  32  current instruction word (instruction memory rd)
- cpu_hold  out  1  1 = CPU must not advance PC nor write memory/registers
- mem_a  out  32  data-memory byte address for the dump read (word index << 2)
- mem_rd  in  32  data-memory read data, combinational w.r.t. mem_a
- out_valid  out  1  out_index/out_data hold a valid word
- out_ready  in  1  sink accepts the word this cycle
- out_index  out  IDX_W  word index of out_data
- out_data  out  32  dumped word
- done  out  1  sticky: all DEPTH words accepted
- checksum  out  32  running checksum (see Configuration)

## Operation
- States: RUN, FILL, STREAM, DONE. Internal rd_ptr (IDX_W+1 bits).
- RUN: cpu_hold=0, out_valid=0. instr sampled each rising edge; instr==HALT_WORD -> FILL, cpu_hold=1 from next cycle.
- FILL: mem_a = 0. Edge: out_data<=mem_rd, out_index<=0, out_valid<=1, rd_ptr<=1 -> STREAM.
- STREAM: mem_a = rd_ptr<<2 (prefetch of next word). Handshake = out_valid & out_ready.
  - Handshake, out_index==DEPTH-1: out_valid<=0, done<=1 -> DONE.
  - Handshake otherwise: out_data<=mem_rd, out_index<=rd_ptr, rd_ptr<=rd_ptr+1.
  - No handshake: out_data/out_index/out_valid held stable (no drop, no change while valid).
- DONE: cpu_hold=1, out_valid=0, done=1; stays until reset. instr ignored.
- instr ignored in FILL/STREAM/DONE; only first halt counts.
- mem_a = 0 in RUN and DONE.
- DEPTH==1: FILL loads word 0; first handshake -> DONE.

## Timing
- Reset (rst_n=0 at rising edge): state RUN, cpu_hold=0, out_valid=0, out_index=0, out_data=0, done=0, checksum=0, rd_ptr=0. Reset in any state aborts the dump immediately; CPU released next cycle.
- Halt seen at edge N: cpu_hold=1 and state FILL after N; out_valid=1 after edge N+1 (2-cycle latency).
- Throughput: 1 word/cycle with out_ready held 1; full dump of DEPTH words completes DEPTH+1 cycles after halt edge; done=1 after edge of last handshake.
- out_ready may toggle arbitrarily; valid never deasserts before handshake.
- mem_rd must settle combinationally within the cycle mem_a is driven; no write occurs during dump because cpu_hold=1.

## Configuration
- MEM_DUMP_CHECKSUM_EN defined: checksum accumulates 32-bit wrap-around sum of out_data on every handshake; cleared on reset; final value valid when done=1, held thereafter.
- Not defined: checksum tied to 32'h0; no accumulator logic.

## Test plan
- Reset: rst_n=0 two cycles with instr=0 -> cpu_hold=0, out_valid=0, done=0, checksum=0; first RUN edge after release with instr=0 starts dump.
- Full-rate dump: DEPTH=4, mem = {11,22,33,44}, out_ready=1, halt at edge N -> valid pairs (0,11),(1,22),(2,33),(3,44) after edges N+1..N+4; done=1 after N+5; checksum=110 with MEM_DUMP_CHECKSUM_EN, 0 without.
- Back-pressure: out_ready=0 for 3 cycles while out_index=1 -> out_index=1, out_data=22 stable throughout; resumes with index 2 after the accepting edge; no word skipped or duplicated.
- Non-halt traffic: instr=32'h2008_0005 for 20 cycles -> remains RUN, cpu_hold=0, mem_a=0, out_valid=0.
- Reset mid-dump: rst_n=0 while out_index=2 -> next edge out_valid=0, cpu_hold=0, done=0, checksum=0; new halt restarts from index 0.
- DEPTH=1: mem[0]=32'hDEAD_BEEF -> single word (0, DEADBEEF), done=1 after its handshake; second halt word afterwards ignored.
